ahbl_sync_sram: RTL and testbench

AHB-Lite slave wrapping a synchronous single-port SRAM with per-byte write enables. It sits on the processor's AHB-Lite bus as zero-wait-state instruction/data memory; simulation benches may load and inspect its contents through a fixed backdoor hierarchy. Responses are always OKAY. Reads and writes complete with no wait states, except one stall cycle for a read directly following a write.

---
 rtl/ahbl_sync_sram.sv | 138 +++++++++++++
 tb/tb_ahbl_sync_sram.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sync_sram.sv
// AHB-Lite slave over a synchronous single-port byte-enable SRAM, zero wait states
// except one stall for a read landing on a write data phase.

module ahbl_sync_sram_mem #(
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  // Block and array names form the backdoor path used for preload and inspection.
  if (1) begin : has_byte_enable
    for (genvar k = 0; k < 4; k++) begin : byte_mem
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (en && we && be[k]) mem[addr] <= wdata[8*k +: 8];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)            rd_q <= 8'h00;
        else if (en && !we) rd_q <= mem[addr];
      end

      assign rdata[8*k +: 8] = rd_q;
    end
  end

  logic unused_init;
  assign unused_init = (INIT_FILE != "");

endmodule

module ahbl_sync_sram #(
  parameter int    W_DATA    = 32,
  parameter int    W_ADDR    = 32,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ahbls_hready_resp,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata
);

  localparam int AW = $clog2(DEPTH);

  logic          ap_valid, ap_read, ap_write, collide;
  logic [3:0]    ap_be;
  logic [AW-1:0] ap_idx;
  logic          wr_pend, rd_pend;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [3:0]    wr_be;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  assign ap_valid = ahbls_hready_resp & ahbls_htrans[1];
  assign ap_read  = ap_valid & ~ahbls_hwrite;
  assign ap_write = ap_valid & ahbls_hwrite;
  assign ap_idx   = ahbls_haddr[AW+1:2];
  // A read address phase during a write data phase loses the single SRAM port.
  assign collide  = ap_read & wr_pend;

  always_comb begin
    ap_be = 4'b1111;
    case (ahbls_hsize)
      3'd0:    ap_be = 4'b0001 << ahbls_haddr[1:0];
      3'd1:    ap_be = ahbls_haddr[1] ? 4'b1100 : 4'b0011;
      default: ap_be = 4'b1111;
    endcase
  end

  always_comb begin
    mem_en   = wr_pend | rd_pend | ap_read;
    mem_we   = wr_pend;
    mem_addr = ap_idx;
    if (wr_pend)      mem_addr = wr_addr;
    else if (rd_pend) mem_addr = rd_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ahbls_hready_resp <= 1'b1;
      wr_pend           <= 1'b0;
      rd_pend           <= 1'b0;
      wr_addr           <= '0;
      wr_be             <= '0;
      rd_addr           <= '0;
    end else begin
      wr_pend           <= ap_write;
      rd_pend           <= collide;
      ahbls_hready_resp <= ~collide;
      if (ap_write) begin
        wr_addr <= ap_idx;
        wr_be   <= ap_be;
      end
      if (collide) rd_addr <= ap_idx;
    end
  end

  assign ahbls_hresp = 1'b0;

  ahbl_sync_sram_mem #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) sram (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (mem_we),
    .be    (wr_be),
    .addr  (mem_addr),
    .wdata (ahbls_hwdata),
    .rdata (ahbls_hrdata)
  );

  logic unused_bus;
  assign unused_bus = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0],
                        ahbls_haddr[W_ADDR-1:AW+2]};

endmodule

// File: tb/tb_ahbl_sync_sram.sv
// Directed bench for ahbl_sync_sram: round trips, byte lanes, collision stall,
// back-to-back reads, aliasing, idle/busy and reset behaviour.

module tb_ahbl_sync_sram;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        hready, hresp, hwrite, hmastlock;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  int n_pass   = 0;
  int n_checks = 0;

  ahbl_sync_sram dut (
    .clk               (clk),
    .rst               (rst),
    .ahbls_hready_resp (hready),
    .ahbls_hresp       (hresp),
    .ahbls_haddr       (haddr),
    .ahbls_hwrite      (hwrite),
    .ahbls_htrans      (htrans),
    .ahbls_hsize       (hsize),
    .ahbls_hburst      (hburst),
    .ahbls_hprot       (hprot),
    .ahbls_hmastlock   (hmastlock),
    .ahbls_hwdata      (hwdata),
    .ahbls_hrdata      (hrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = wdata;
  endtask

  task automatic bd_write(input int idx, input logic [31:0] d);
    dut.sram.has_byte_enable.byte_mem[0].mem[idx] = d[7:0];
    dut.sram.has_byte_enable.byte_mem[1].mem[idx] = d[15:8];
    dut.sram.has_byte_enable.byte_mem[2].mem[idx] = d[23:16];
    dut.sram.has_byte_enable.byte_mem[3].mem[idx] = d[31:24];
  endtask

  function automatic logic [31:0] bd_read(input int idx);
    return {dut.sram.has_byte_enable.byte_mem[3].mem[idx],
            dut.sram.has_byte_enable.byte_mem[2].mem[idx],
            dut.sram.has_byte_enable.byte_mem[1].mem[idx],
            dut.sram.has_byte_enable.byte_mem[0].mem[idx]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    hburst    = 3'd0;
    hprot     = 4'h3;
    hmastlock = 1'b0;
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    bd_write(0, 32'h1);
    bd_write(1, 32'h2);
    bd_write(2, 32'h3);
    bd_write(24, 32'h11112222);
    repeat (3) tick();
    check("rst_hready", hready, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    rst = 1'b0;
    tick();

    // Word round trip
    drive(NSEQ, 1'b1, 32'h10, 3'd2, 32'h0); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'hDEADBEEF);
    check("wr_hready", hready, 1); tick();
    check("wr_mem", bd_read(4), 32'hDEADBEEF);
    drive(NSEQ, 1'b0, 32'h10, 3'd2, 32'h0); tick();
    check("rd_hready", hready, 1);
    check("rd_data", hrdata, 32'hDEADBEEF);
    check("rd_hresp", hresp, 0);

    // Read then write: no stall
    drive(NSEQ, 1'b0, 32'h10, 3'd2, 32'h0); tick();
    drive(NSEQ, 1'b1, 32'h44, 3'd2, 32'h0);
    check("rw_hready_rd", hready, 1);
    check("rw_data", hrdata, 32'hDEADBEEF); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'hCAFEF00D);
    check("rw_hready_wr", hready, 1); tick();
    check("rw_mem", bd_read(17), 32'hCAFEF00D);

    // Byte lanes: word, byte at 0x22, halfword at 0x20
    drive(NSEQ, 1'b1, 32'h20, 3'd2, 32'h0); tick();
    drive(SEQ, 1'b1, 32'h22, 3'd0, 32'h00000000); tick();
    drive(NSEQ, 1'b1, 32'h20, 3'd1, 32'h00AB0000);
    check("lane_hready", hready, 1); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'hFFFF1234); tick();
    check("lane_mem", bd_read(8), 32'h00AB1234);
    drive(NSEQ, 1'b0, 32'h20, 3'd2, 32'h0); tick();
    check("lane_data", hrdata, 32'h00AB1234);
    drive(NSEQ, 1'b1, 32'h23, 3'd0, 32'h0); tick();
    drive(NSEQ, 1'b1, 32'h22, 3'd1, 32'h77FFFFFF); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h5566FFFF); tick();
    check("lane_upper", bd_read(8), 32'h55661234);

    // Write immediately followed by read of the same word
    drive(NSEQ, 1'b1, 32'h40, 3'd2, 32'h0); tick();
    drive(NSEQ, 1'b0, 32'h40, 3'd2, 32'h55AA55AA);
    check("col_hready_wr", hready, 1); tick();
    check("col_stall", hready, 0); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    check("col_hready_done", hready, 1);
    check("col_data", hrdata, 32'h55AA55AA); tick();
    check("col_after", hready, 1);

    // Back-to-back reads of preloaded words
    drive(NSEQ, 1'b0, 32'h0, 3'd2, 32'h0); tick();
    drive(SEQ, 1'b0, 32'h4, 3'd2, 32'h0);
    check("b2b_hready0", hready, 1);
    check("b2b_data0", hrdata, 32'h1); tick();
    drive(SEQ, 1'b0, 32'h8, 3'd2, 32'h0);
    check("b2b_hready1", hready, 1);
    check("b2b_data1", hrdata, 32'h2); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    check("b2b_hready2", hready, 1);
    check("b2b_data2", hrdata, 32'h3); tick();

    // Aliasing, with BUSY and IDLE (write flag set) that must not touch memory
    drive(NSEQ, 1'b1, 32'h400, 3'd2, 32'h0); tick();
    drive(BUSY, 1'b1, 32'h0, 3'd2, 32'h1);
    check("alias_hready_wr", hready, 1); tick();
    check("alias_mem", bd_read(0), 32'h1);
    drive(IDLE, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF);
    check("busy_hready", hready, 1); tick();
    drive(NSEQ, 1'b0, 32'h0, 3'd2, 32'hFFFFFFFF);
    check("idle_hready", hready, 1); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    check("alias_data", hrdata, 32'h1);
    check("idle_nowrite", bd_read(0), 32'h1); tick();

    // Reset during a write data phase discards the write
    drive(NSEQ, 1'b1, 32'h60, 3'd2, 32'h0); tick();
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h99999999);
    #2 rst = 1'b1;
    #1;
    check("rstw_hready", hready, 1);
    check("rstw_hrdata", hrdata, 0);
    check("rstw_hresp", hresp, 0);
    tick();
    rst = 1'b0;
    check("rstw_mem", bd_read(24), 32'h11112222);
    tick();

    // Reset during a collision stall releases hready and drops the pending read
    drive(NSEQ, 1'b1, 32'h64, 3'd2, 32'h0); tick();
    drive(NSEQ, 1'b0, 32'h64, 3'd2, 32'h77); tick();
    check("rsts_stall", hready, 0);
    #2 rst = 1'b1;
    #1;
    check("rsts_hready", hready, 1);
    tick();
    rst = 1'b0;
    drive(IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    tick();
    check("rsts_after", hready, 1);
    check("rsts_hrdata", hrdata, 0);
    check("rsts_mem", bd_read(25), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
